// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED matrix frame path: frame geometry, number of
// frame sources and the frame scheduler state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package led_pkg;

    localparam int LED_ROWS    = 32;  // rows per frame, fixed by the driver
    localparam int LED_ROW_W   = 5;   // width of a row index
    localparam int LED_NUM_SRC = 2;   // 0: beam-pattern generator, 1: test source

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        DRAIN     = 2'd2,
        WAIT_DONE = 2'd3
    } led_sched_state_t;

endpackage

// File: rtl/led_rr_arbiter.sv
// ----------------------------------------------------------------------------
// led_rr_arbiter
// Two-way round-robin arbiter. gnt_next is the combinational one-hot winner
// for the current requests; the last-grant pointer only moves when the
// owner of this arbiter commits a grant via advance.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req[1:0]        per-source requests
//   advance         commit gnt_next as the new last grant
//   gnt_next[1:0]   one-hot winner (0 when nothing requests)
// ----------------------------------------------------------------------------
module led_rr_arbiter
    import led_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LED_NUM_SRC-1:0] req,
    input  logic                   advance,
    output logic [LED_NUM_SRC-1:0] gnt_next
);

    // High when source 1 won the most recent arbitration.
    logic last_src1;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unhandled path keeps the old value and infers a latch.
        gnt_next = '0;
        case (req)
            2'b01:   gnt_next = 2'b01;
            2'b10:   gnt_next = 2'b10;
            2'b11:   gnt_next = last_src1 ? 2'b01 : 2'b10;
            default: gnt_next = '0;
        endcase
    end

    // Reset pretends source 1 went last, so source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src1 <= 1'b1;
        end else if (advance) begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples its inputs from the same pre-edge values.
            last_src1 <= gnt_next[1];
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// ----------------------------------------------------------------------------
// led_frame_scheduler
// Shares led32x32_matrix_driver between two frame sources. Arbitrates, reads
// one full frame from the winner into the driver's row-write port, then
// blocks further loads until the driver reports frame_done so the frame
// buffer is never rewritten while it is being scanned.
//
// Optional feature: define LED_FRAME_SCHED_TIMEOUT_EN to bound the
// frame_done wait to DONE_TIMEOUT cycles (sets sticky timeout_err).
//
// Parameters:
//   ROWS           rows per frame (fixed at 32 by the driver)
//   DONE_TIMEOUT   frame_done wait limit in cycles (timeout build only)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                low aborts any activity and returns to IDLE
//   req[1:0]              per-source frame requests (level)
//   gnt[1:0]              one-hot grant, held through the last row read
//   rd_en, rd_idx         row read strobe / index to the granted source
//   rd_data0, rd_data1    source row data, valid one cycle after rd_en
//   row_valid, row_idx,   registered row write to the driver
//   row_data
//   frame_done            driver frame-complete pulse
//   busy                  high in every state except IDLE
//   frame_cnt             completed frames (wraps)
//   timeout_err           sticky frame_done timeout flag
// ----------------------------------------------------------------------------
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int          ROWS         = LED_ROWS,
    parameter logic [15:0] DONE_TIMEOUT = 16'd4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [LED_NUM_SRC-1:0] req,
    output logic [LED_NUM_SRC-1:0] gnt,
    output logic                   rd_en,
    output logic [LED_ROW_W-1:0]   rd_idx,
    input  logic [31:0]            rd_data0,
    input  logic [31:0]            rd_data1,
    output logic                   row_valid,
    output logic [LED_ROW_W-1:0]   row_idx,
    output logic [31:0]            row_data,
    input  logic                   frame_done,
    output logic                   busy,
    output logic [15:0]            frame_cnt,
    output logic                   timeout_err
);

    led_sched_state_t             state;
    led_sched_state_t             state_next;
    logic [LED_NUM_SRC-1:0]       gnt_next;
    logic                         advance;
    logic                         last_row;
    logic                         drain_second;
    logic                         tmo_hit;

    // One-cycle delayed copy of the read strobe: marks the cycle in which the
    // source presents the row requested one cycle earlier.
    logic                         rd_pend;
    logic [LED_ROW_W-1:0]         rd_pend_idx;

    assign advance  = enable && (state == IDLE) && (req != '0);
    assign last_row = (rd_idx == LED_ROW_W'(ROWS - 1));

    led_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .advance  (advance),
        .gnt_next (gnt_next)
    );

`ifdef LED_FRAME_SCHED_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counts cycles spent in WAIT_DONE; restarts from 0 on every entry.
    assign tmo_hit = (state == WAIT_DONE) && !frame_done &&
                     (tmo_cnt == DONE_TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != WAIT_DONE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (enable && tmo_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^DONE_TIMEOUT;
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (req != '0)              state_next = LOAD;
                LOAD:      if (last_row)               state_next = DRAIN;
                DRAIN:     if (drain_second)           state_next = WAIT_DONE;
                WAIT_DONE: if (frame_done || tmo_hit)  state_next = IDLE;
                default:                               state_next = IDLE;
            endcase
        end
    end

    // Control path: state, grant, read sequencing and frame counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: only control/pipeline flops here, all reset; there is no
            // storage array that would be costly to clear.
            state        <= IDLE;
            busy         <= 1'b0;
            gnt          <= '0;
            rd_en        <= 1'b0;
            rd_idx       <= '0;
            drain_second <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            if (!enable) begin
                gnt          <= '0;
                rd_en        <= 1'b0;
                rd_idx       <= '0;
                drain_second <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (advance) begin
                            gnt    <= gnt_next;
                            rd_en  <= 1'b1;
                            rd_idx <= '0;
                        end
                    end
                    LOAD: begin
                        if (last_row) begin
                            rd_en        <= 1'b0;
                            rd_idx       <= '0;
                            drain_second <= 1'b0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                    // Two cycles let rows 30 and 31 leave the pipeline while
                    // gnt still selects the source data mux.
                    DRAIN: begin
                        if (drain_second) begin
                            gnt          <= '0;
                            drain_second <= 1'b0;
                        end else begin
                            drain_second <= 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        if (frame_done) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Data path: capture the selected source row and present it to the
    // driver. Dropping enable flushes it so a partial frame never reaches
    // row 31 and cannot arm the driver's frame sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend     <= 1'b0;
            rd_pend_idx <= '0;
            row_valid   <= 1'b0;
            row_idx     <= '0;
            row_data    <= '0;
        end else if (!enable) begin
            rd_pend   <= 1'b0;
            row_valid <= 1'b0;
        end else begin
            rd_pend     <= rd_en;
            rd_pend_idx <= rd_idx;
            row_valid   <= rd_pend;
            if (rd_pend) begin
                row_idx  <= rd_pend_idx;
                row_data <= gnt[1] ? rd_data1 : rd_data0;
            end
        end
    end

endmodule
